// File: rtl/cordic_arbiter.sv
// Two-requester round-robin front end for one shared combinational CORDIC core; optional range check via CORDIC_ARB_RANGE_CHECK_EN.
// Latency: response valid SETTLE+1 cycles after the accept cycle (1 cycle for an out-of-range angle when the check is built in).
// Backpressure: one transaction in flight; requesters see ready only in IDLE, and RESP holds until rsp_ready.
module cordic_arbiter #(
    parameter int               width  = 32,
    parameter int               SETTLE = 2,
    parameter logic [width-1:0] X_INIT = 32'd163008219
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [width-1:0] req0_angle,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [width-1:0] req1_angle,
    output logic             req1_ready,
    output logic [width-1:0] core_x_start,
    output logic [width-1:0] core_y_start,
    output logic [width-1:0] core_angle,
    input  logic [width-1:0] core_cosine,
    input  logic [width-1:0] core_sine,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [width-1:0] rsp_cos,
    output logic [width-1:0] rsp_sin,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q;
    logic             last_q;
    logic             grant_id;
    logic             accept;
    logic             wait_done;
    logic             out_of_range;
    logic [width-1:0] angle_sel;

    assign angle_sel = grant_id ? req1_angle : req0_angle;
    assign wait_done = (cnt_q == 4'(SETTLE - 1));

`ifdef CORDIC_ARB_RANGE_CHECK_EN
    localparam logic signed [width-1:0] ANGLE_MAX = 1686628080;
    logic err_q;
    assign out_of_range = ($signed(angle_sel) > ANGLE_MAX);
    assign rsp_err      = err_q;
`else
    assign out_of_range = 1'b0;
    assign rsp_err      = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        // A tie goes to whoever was not granted last; a lone request wins outright.
        grant_id   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        case (state_q)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_d    = out_of_range ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_done) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= 1'b1;
            core_x_start <= '0;
            core_y_start <= '0;
            core_angle   <= '0;
            rsp_id       <= 1'b0;
            rsp_cos      <= '0;
            rsp_sin      <= '0;
`ifdef CORDIC_ARB_RANGE_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q <= grant_id;
                rsp_id <= grant_id;
                cnt_q  <= '0;
`ifdef CORDIC_ARB_RANGE_CHECK_EN
                err_q  <= out_of_range;
`endif
                if (out_of_range) begin
                    rsp_cos <= '0;
                    rsp_sin <= '0;
                end else begin
                    core_angle   <= angle_sel;
                    core_x_start <= X_INIT;
                    core_y_start <= '0;
                end
            end
            if (state_q == WAIT) begin
                cnt_q <= cnt_q + 4'd1;
                // Core has had SETTLE cycles on stable inputs by this edge.
                if (wait_done) begin
                    rsp_cos <= core_cosine;
                    rsp_sin <= core_sine;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a one-cycle-latency stand-in for the shared core.
// Covers reset, single request, tie alternation, backpressure, reset mid-WAIT and the range check.
module tb_cordic_arbiter;

    localparam logic [31:0] X0  = 32'd163008219;
    localparam logic [31:0] A45 = 32'd210828714;
    localparam logic [31:0] ABIG = 32'd1700000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_angle, req1_angle;
    logic        req0_ready, req1_ready;
    logic [31:0] core_x_start, core_y_start, core_angle;
    logic [31:0] core_cosine, core_sine;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_cos, rsp_sin;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cordic_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_angle   (req0_angle),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_angle   (req1_angle),
        .req1_ready   (req1_ready),
        .core_x_start (core_x_start),
        .core_y_start (core_y_start),
        .core_angle   (core_angle),
        .core_cosine  (core_cosine),
        .core_sine    (core_sine),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_cos      (rsp_cos),
        .rsp_sin      (rsp_sin),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    function automatic logic [31:0] m_cos(input logic [31:0] x, input logic [31:0] a);
        logic signed [31:0] h;
        h = $signed(a) >>> 1;
        return x - h;
    endfunction

    function automatic logic [31:0] m_sin(input logic [31:0] y, input logic [31:0] a);
        logic signed [31:0] h;
        h = $signed(a) >>> 1;
        return y + h;
    endfunction

    // Core stand-in: results lag the core inputs by one cycle, so early capture is visible.
    always_ff @(posedge clk) begin
        core_cosine <= m_cos(core_x_start, core_angle);
        core_sine   <= m_sin(core_y_start, core_angle);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin : stim
        int   gap;
        logic got;
        logic seen;

        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_angle = A45;
        req1_angle = '0;
        rsp_ready  = 1'b0;

        // Reset: every output low even with a request pending.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_core_x", core_x_start, 0);
        chk("rst_core_angle", core_angle, 0);
        chk("rst_rsp_cos", rsp_cos, 0);
        chk("rst_rsp_err", rsp_err, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request on req0, 45 degrees.
        @(negedge clk);
        req0_valid = 1'b1;
        req0_angle = A45;
        #1;
        chk("s_req0_ready", req0_ready, 1);
        chk("s_req1_ready", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("s_busy_wait", busy, 1);
        chk("s_core_angle", core_angle, A45);
        chk("s_core_x", core_x_start, X0);
        chk("s_core_y", core_y_start, 0);
        chk("s_vld_c1", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("s_vld_c2", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("s_vld_c3", rsp_valid, 1);
        chk("s_id", rsp_id, 0);
        chk("s_cos", rsp_cos, m_cos(X0, A45));
        chk("s_sin", rsp_sin, m_sin(32'd0, A45));
        chk("s_err", rsp_err, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("s_idle_vld", rsp_valid, 0);
        chk("s_idle_busy", busy, 0);

        // Tie from reset: grants alternate 0,1,0,1 at minimum spacing.
        rsp_ready  = 1'b0;
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_angle = 32'd1000;
        req1_angle = 32'd2000;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            gap = 0;
            got = 1'b0;
            if (t == 0) begin
                @(negedge clk);
                #1;
                got = req0_ready | req1_ready;
            end
            while (!got && gap < 12) begin
                @(negedge clk);
                #1;
                gap++;
                got = req0_ready | req1_ready;
            end
            chk("tie_grant_seen", got, 1);
            chk("tie_grant_id", req1_ready, (t % 2 == 1) ? 1 : 0);
            chk("tie_onehot", req0_ready ^ req1_ready, 1);
            if (t > 0) chk("tie_accept_gap", gap, 4);
        end

        // Backpressure on the fourth (req1, angle 2000) response.
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 1);
            chk("bp_cos", rsp_cos, m_cos(X0, 32'd2000));
            chk("bp_sin", rsp_sin, m_sin(32'd0, 32'd2000));
            chk("bp_req0_ready", req0_ready, 0);
            chk("bp_req1_ready", req1_ready, 0);
            chk("bp_busy", busy, 1);
            @(negedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_busy", busy, 0);
        chk("bp_release_vld", rsp_valid, 0);
        rsp_ready = 1'b0;

        // Reset pulse during WAIT cycle 1.
        @(negedge clk);
        req0_valid = 1'b1;
        req0_angle = A45;
        #1;
        chk("rw_req0_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("rw_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_rsp_valid", rsp_valid, 0);
        chk("rw_core_angle", core_angle, 0);
        chk("rw_core_x", core_x_start, 0);
        chk("rw_rsp_cos", rsp_cos, 0);
        chk("rw_rsp_id", rsp_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            seen = seen | rsp_valid | busy;
        end
        chk("rw_no_response", seen, 0);
        rsp_ready = 1'b0;

        // Out-of-range angle on req1 alone (pointer favours req0 after reset).
        @(negedge clk);
        req1_valid = 1'b1;
        req1_angle = ABIG;
        #1;
        chk("rc_req1_ready", req1_ready, 1);
        chk("rc_req0_ready", req0_ready, 0);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
`ifdef CORDIC_ARB_RANGE_CHECK_EN
        chk("rc_vld_c1", rsp_valid, 1);
        chk("rc_err", rsp_err, 1);
        chk("rc_id", rsp_id, 1);
        chk("rc_cos", rsp_cos, 0);
        chk("rc_sin", rsp_sin, 0);
        chk("rc_core_angle", core_angle, 0);
        chk("rc_core_x", core_x_start, 0);
`else
        chk("rc_vld_c1", rsp_valid, 0);
        chk("rc_core_angle", core_angle, ABIG);
        @(negedge clk);
        #1;
        chk("rc_vld_c2", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("rc_vld_c3", rsp_valid, 1);
        chk("rc_err", rsp_err, 0);
        chk("rc_id", rsp_id, 1);
        chk("rc_cos", rsp_cos, m_cos(X0, ABIG));
        chk("rc_sin", rsp_sin, m_sin(32'd0, ABIG));
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rc_done_busy", busy, 0);
        rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 The block SHALL have parameter width, default 32, giving the data width of angles and results.
REQ-002 The block SHALL have parameter SETTLE, default 2, range 1..15, giving the number of cycles the shared combinational CORDIC core is allowed to settle before capture.
REQ-003 The block SHALL have parameter X_INIT, default 32'd163008219, giving the CORDIC gain-compensated start vector (0.607253 x 2^28).
REQ-004 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 Ports req0_valid / req1_valid, input, 1 each, a requester presents an angle.
REQ-007 Ports req0_angle / req1_angle, input, width each, the signed angle, 2^28 = 1 rad.
REQ-008 Ports req0_ready / req1_ready, output, 1 each, acceptance strobe.
REQ-009 Ports core_x_start, core_y_start, core_angle, output, width each, registered drive into the shared core.
REQ-010 Ports core_cosine, core_sine, input, width each, the shared core results.
REQ-011 Ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_id (output, 1), rsp_cos (output, width), rsp_sin (output, width) and rsp_err (output, 1) form the response channel.
REQ-012 Port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, WAIT, RESP.
REQ-014 IDLE with any reqN_valid SHALL grant exactly one requester, raise its reqN_ready combinationally for that cycle, and move to WAIT on the clock edge.
REQ-015 At the accept edge the block SHALL register core_angle = granted angle, core_x_start = X_INIT, core_y_start = 0, and the granted id.
REQ-016 When both requests are valid, the grant SHALL go to the requester not granted last; a single valid request SHALL be granted regardless of the pointer.
REQ-017 The last-grant pointer SHALL update only on acceptance.
REQ-018 WAIT SHALL count SETTLE cycles; on the last WAIT cycle rsp_cos/rsp_sin SHALL capture core_cosine/core_sine; the FSM then enters RESP.
REQ-019 rsp_valid SHALL be high exactly in RESP, i.e. SETTLE+1 cycles after the accept edge.
REQ-020 RESP SHALL hold rsp_valid and all rsp_* outputs stable until the rsp_ready edge, then return to IDLE.
REQ-021 No reqN_ready SHALL assert outside IDLE; a requester that drops valid before being granted loses no state.
REQ-022 core_* outputs SHALL hold their last value outside WAIT.
REQ-023 Back-to-back operation SHALL give a minimum of SETTLE+2 cycles between accepts.

Reset
REQ-024 While rst_n is low, all outputs SHALL be 0 (busy, rsp_valid, reqN_ready included), state SHALL be IDLE, the WAIT counter 0, and the last-grant pointer 1 so that requester 0 wins the first tie.
REQ-025 Reset asserted mid-WAIT or mid-RESP SHALL abort the transaction with no response emitted after release.

Configuration
REQ-026 With macro CORDIC_ARB_RANGE_CHECK_EN defined, a granted angle > 32'd1686628080 SHALL skip WAIT and enter RESP on the next edge with rsp_err = 1 and rsp_cos = rsp_sin = 0, and core_* SHALL remain unchanged.
REQ-027 Without CORDIC_ARB_RANGE_CHECK_EN, every angle SHALL be forwarded to the core and rsp_err SHALL be tied 0.

Verification
REQ-028 Single request: req0 with angle 210828714 (45 deg) and a core model. The response SHALL be rsp_valid at accept+3 (SETTLE=2), with rsp_id=0 and rsp_cos and rsp_sin equal to the model outputs.
REQ-029 Tie: req0 and req1 held valid for 4 transactions from reset. Grants SHALL go 0,1,0,1.
REQ-030 Backpressure: rsp_ready held low 10 cycles in RESP. rsp_* SHALL stay stable, both ready signals SHALL stay 0, and busy SHALL stay 1.
REQ-031 Reset mid-WAIT: rst_n pulsed low on WAIT cycle 1. All outputs SHALL read 0 immediately, and no rsp_valid SHALL occur.
REQ-032 Range check: req1 with angle 1700000000. With the macro, rsp_err SHALL be 1 at accept+1 and rsp_id SHALL be 1. Without the macro, the response SHALL arrive at accept+3 with rsp_err 0.
